// File: rtl/lbp_upd_pkg.sv
// lbp_upd_pkg: shared widths, in-flight entry type and pointer helpers for lbp_update_ctrl.
package lbp_upd_pkg;

    localparam int unsigned VLEN     = 64;
    localparam int unsigned IDX_BITS = 7;
    localparam int unsigned DEPTH    = 8;
    localparam int unsigned PTR_W    = $clog2(DEPTH) + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    typedef struct packed {
        logic [VLEN-1:0]     pc;
        logic                pred_taken;
        logic                pred_valid;
        logic [IDX_BITS-1:0] index;
    } lbp_upd_entry_t;

    // Pointers carry one extra wrap bit: same slot with different laps means full.
    function automatic logic ptr_full(ptr_t wr, ptr_t rd);
        return (wr[PTR_W-1] != rd[PTR_W-1]) && (wr[PTR_W-2:0] == rd[PTR_W-2:0]);
    endfunction

    function automatic logic ptr_empty(ptr_t wr, ptr_t rd);
        return wr == rd;
    endfunction

endpackage

// File: rtl/lbp_update_ctrl_if.sv
// lbp_update_ctrl_if: record/resolve/update bundle of lbp_update_ctrl.
//   slave  : the controller (takes rec_*/res_*, drives rec_ready, upd_*, mispredict, underflow, count)
//   master : frontend + branch unit side
//   pc_mismatch exists only when LBP_UPD_PC_CHECK_EN is defined.
interface lbp_update_ctrl_if;
    import lbp_upd_pkg::*;

    logic                rec_valid;
    logic                rec_ready;
    logic [VLEN-1:0]     rec_pc;
    logic                rec_pred_taken;
    logic                rec_pred_valid;
    logic [IDX_BITS-1:0] rec_index;
    logic                res_valid;
    logic [VLEN-1:0]     res_pc;
    logic                res_taken;
    logic                upd_valid;
    logic [VLEN-1:0]     upd_pc;
    logic                upd_taken;
    logic [IDX_BITS-1:0] upd_index;
    logic                mispredict;
    logic                underflow;
    logic [PTR_W-1:0]    count;
`ifdef LBP_UPD_PC_CHECK_EN
    logic                pc_mismatch;

    modport slave (
        input  rec_valid, rec_pc, rec_pred_taken, rec_pred_valid, rec_index,
        input  res_valid, res_pc, res_taken,
        output rec_ready, upd_valid, upd_pc, upd_taken, upd_index,
        output mispredict, underflow, count, pc_mismatch
    );

    modport master (
        output rec_valid, rec_pc, rec_pred_taken, rec_pred_valid, rec_index,
        output res_valid, res_pc, res_taken,
        input  rec_ready, upd_valid, upd_pc, upd_taken, upd_index,
        input  mispredict, underflow, count, pc_mismatch
    );
`else
    modport slave (
        input  rec_valid, rec_pc, rec_pred_taken, rec_pred_valid, rec_index,
        input  res_valid, res_pc, res_taken,
        output rec_ready, upd_valid, upd_pc, upd_taken, upd_index,
        output mispredict, underflow, count
    );

    modport master (
        output rec_valid, rec_pc, rec_pred_taken, rec_pred_valid, rec_index,
        output res_valid, res_pc, res_taken,
        input  rec_ready, upd_valid, upd_pc, upd_taken, upd_index,
        input  mispredict, underflow, count
    );
`endif

endinterface

// File: rtl/lbp_upd_fifo.sv
// lbp_upd_fifo: in-order store of in-flight branch entries.
//   clk_i, rst_ni (async active-low), flush_i : clear both pointers
//   push_i/wdata_i : append (ignored when full); pop_i : drop head (ignored when empty)
//   rdata_o : head entry; full_o, empty_o, count_o : registered-state status
module lbp_upd_fifo
    import lbp_upd_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           flush_i,
    input  logic           push_i,
    input  logic           pop_i,
    input  lbp_upd_entry_t wdata_i,
    output lbp_upd_entry_t rdata_o,
    output logic           full_o,
    output logic           empty_o,
    output ptr_t           count_o
);

    lbp_upd_entry_t mem [DEPTH];
    ptr_t           wr_ptr;
    ptr_t           rd_ptr;
    logic           wr_en;
    logic           rd_en;

    assign full_o  = ptr_full(wr_ptr, rd_ptr);
    assign empty_o = ptr_empty(wr_ptr, rd_ptr);
    assign count_o = wr_ptr - rd_ptr;
    assign rdata_o = mem[rd_ptr[PTR_W-2:0]];
    assign wr_en   = push_i && !full_o && !flush_i;
    assign rd_en   = pop_i && !empty_o && !flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + ptr_t'(1);
            if (rd_en) rd_ptr <= rd_ptr + ptr_t'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr[PTR_W-2:0]] <= wdata_i;
    end

endmodule

// File: rtl/lbp_update_ctrl.sv
// lbp_update_ctrl: holds lbp prediction metadata per in-flight branch and drives bht updates on resolve.
//   clk_i, rst_ni (async active-low), flush_i (squash all), debug_mode_i (mask upd_valid)
//   bus (lbp_update_ctrl_if.slave) : record, resolve, update, mispredict/underflow pulses, count
//   Optional LBP_UPD_PC_CHECK_EN: resolve PC is checked against the stored PC; a mismatch
//   pops the entry silently and pulses bus.pc_mismatch.
module lbp_update_ctrl
    import lbp_upd_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               debug_mode_i,
    lbp_update_ctrl_if.slave   bus
);

    lbp_upd_entry_t head;
    lbp_upd_entry_t rec_entry;
    logic           full;
    logic           empty;
    logic           pop;
    logic           pc_bad;
    logic           dir_wrong;

    assign rec_entry = '{pc: bus.rec_pc, pred_taken: bus.rec_pred_taken,
                         pred_valid: bus.rec_pred_valid, index: bus.rec_index};

    lbp_upd_fifo u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (bus.rec_valid),
        .pop_i   (bus.res_valid),
        .wdata_i (rec_entry),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (bus.count)
    );

    assign bus.rec_ready = !full;
    assign pop           = bus.res_valid && !empty && !flush_i;
    assign dir_wrong     = head.pred_valid && (head.pred_taken != bus.res_taken);

`ifdef LBP_UPD_PC_CHECK_EN
    assign pc_bad = bus.res_pc != head.pc;
`else
    assign pc_bad = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.upd_valid   <= 1'b0;
            bus.upd_pc      <= '0;
            bus.upd_taken   <= 1'b0;
            bus.upd_index   <= '0;
            bus.mispredict  <= 1'b0;
            bus.underflow   <= 1'b0;
`ifdef LBP_UPD_PC_CHECK_EN
            bus.pc_mismatch <= 1'b0;
`endif
        end else begin
            bus.upd_valid   <= pop && !pc_bad && !debug_mode_i;
            bus.mispredict  <= pop && !pc_bad && dir_wrong;
            bus.underflow   <= bus.res_valid && empty && !flush_i;
`ifdef LBP_UPD_PC_CHECK_EN
            bus.pc_mismatch <= pop && pc_bad;
`endif
            if (pop) begin
                bus.upd_pc    <= head.pc;
                bus.upd_index <= head.index;
                bus.upd_taken <= bus.res_taken;
            end
        end
    end

endmodule

// File: tb/tb_lbp_update_ctrl.sv
// tb_lbp_update_ctrl: directed self-checking bench for lbp_update_ctrl.
module tb_lbp_update_ctrl;
    import lbp_upd_pkg::*;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic flush_i = 1'b0;
    logic debug_mode_i = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    lbp_upd_entry_t q[$];
    lbp_upd_entry_t e;
    lbp_upd_entry_t n;

    always #5 clk = ~clk;

    lbp_update_ctrl_if bus ();

    lbp_update_ctrl dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .debug_mode_i (debug_mode_i),
        .bus          (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rec(input logic [63:0] pc, input logic pt, input logic pv, input logic [6:0] idx);
        bus.rec_valid      = 1'b1;
        bus.rec_pc         = pc;
        bus.rec_pred_taken = pt;
        bus.rec_pred_valid = pv;
        bus.rec_index      = idx;
    endtask

    task automatic res(input logic [63:0] pc, input logic taken);
        bus.res_valid = 1'b1;
        bus.res_pc    = pc;
        bus.res_taken = taken;
    endtask

    task automatic quiet();
        bus.rec_valid = 1'b0;
        bus.res_valid = 1'b0;
        flush_i       = 1'b0;
        debug_mode_i  = 1'b0;
    endtask

    initial begin
        quiet();
        bus.rec_pc = '0; bus.rec_pred_taken = 0; bus.rec_pred_valid = 0; bus.rec_index = '0;
        bus.res_pc = '0; bus.res_taken = 0;
        repeat (2) tick();
        check("rst_count", 64'(bus.count), 0);
        check("rst_ready", 64'(bus.rec_ready), 1);
        check("rst_upd_valid", 64'(bus.upd_valid), 0);
        check("rst_upd_pc", bus.upd_pc, 0);
        check("rst_mispredict", 64'(bus.mispredict), 0);
        check("rst_underflow", 64'(bus.underflow), 0);
        rst_ni = 1'b1;
        tick();
        check("idle_upd_valid", 64'(bus.upd_valid), 0);
        check("idle_count", 64'(bus.count), 0);

        res(64'h0, 1'b1);
        tick();
        quiet();
        check("uflow_pulse", 64'(bus.underflow), 1);
        check("uflow_no_upd", 64'(bus.upd_valid), 0);
        check("uflow_count", 64'(bus.count), 0);
        tick();
        check("uflow_clear", 64'(bus.underflow), 0);

        rec(64'h1000, 1'b1, 1'b1, 7'd5);
        tick();
        quiet();
        check("basic_count1", 64'(bus.count), 1);
        res(64'h1000, 1'b0);
        tick();
        quiet();
        check("basic_upd_valid", 64'(bus.upd_valid), 1);
        check("basic_upd_pc", bus.upd_pc, 64'h1000);
        check("basic_upd_index", 64'(bus.upd_index), 5);
        check("basic_upd_taken", 64'(bus.upd_taken), 0);
        check("basic_mispredict", 64'(bus.mispredict), 1);
        check("basic_count0", 64'(bus.count), 0);
        tick();
        check("basic_valid_drop", 64'(bus.upd_valid), 0);
        check("basic_mis_drop", 64'(bus.mispredict), 0);

        for (int i = 0; i < 8; i++) begin
            n = '{pc: 64'(32'h100 + 4 * i), pred_taken: (i % 2) == 1, pred_valid: 1'b1, index: 7'(i)};
            rec(n.pc, n.pred_taken, n.pred_valid, n.index);
            q.push_back(n);
            tick();
        end
        quiet();
        check("full_count", 64'(bus.count), 8);
        check("full_ready", 64'(bus.rec_ready), 0);
        rec(64'hdead, 1'b1, 1'b1, 7'd99);
        e = q.pop_front();
        res(e.pc, 1'b0);
        tick();
        quiet();
        check("full_refuse_count", 64'(bus.count), 7);
        check("full_pop_pc", bus.upd_pc, e.pc);
        check("full_pop_mis", 64'(bus.mispredict), 0);
        check("full_ready_back", 64'(bus.rec_ready), 1);

        for (int k = 0; k < 20; k++) begin
            e = q.pop_front();
            n = '{pc: 64'(32'h4000 + 8 * k), pred_taken: (k % 4) >= 2, pred_valid: 1'b1, index: 7'(k + 32)};
            rec(n.pc, n.pred_taken, n.pred_valid, n.index);
            q.push_back(n);
            res(e.pc, (k % 2) == 1);
            tick();
            check("il_upd_valid", 64'(bus.upd_valid), 1);
            check("il_upd_pc", bus.upd_pc, e.pc);
            check("il_upd_index", 64'(bus.upd_index), 64'(e.index));
            check("il_upd_taken", 64'(bus.upd_taken), 64'((k % 2) == 1));
            check("il_mispredict", 64'(bus.mispredict), 64'(e.pred_taken != ((k % 2) == 1)));
            check("il_count", 64'(bus.count), 7);
        end
        quiet();
        while (q.size() > 0) begin
            e = q.pop_front();
            res(e.pc, 1'b1);
            tick();
            check("drain_upd_pc", bus.upd_pc, e.pc);
            check("drain_mispredict", 64'(bus.mispredict), 64'(!e.pred_taken));
            check("drain_count", 64'(bus.count), 64'(q.size()));
        end
        quiet();
        tick();
        check("drain_empty_count", 64'(bus.count), 0);
        check("drain_valid_drop", 64'(bus.upd_valid), 0);

        for (int i = 0; i < 3; i++) begin
            rec(64'(32'h500 + 4 * i), 1'b1, 1'b1, 7'(i));
            tick();
        end
        quiet();
        check("flush_pre_count", 64'(bus.count), 3);
        rec(64'h600, 1'b0, 1'b1, 7'd3);
        res(64'h500, 1'b0);
        flush_i = 1'b1;
        tick();
        quiet();
        check("flush_count", 64'(bus.count), 0);
        check("flush_no_upd", 64'(bus.upd_valid), 0);
        check("flush_no_mis", 64'(bus.mispredict), 0);
        check("flush_no_uflow", 64'(bus.underflow), 0);
        res(64'h500, 1'b0);
        tick();
        quiet();
        check("flush_then_uflow", 64'(bus.underflow), 1);

        rec(64'h3000, 1'b1, 1'b1, 7'd9);
        tick();
        quiet();
        debug_mode_i = 1'b1;
        res(64'h3000, 1'b0);
        tick();
        quiet();
        check("dbg_no_upd", 64'(bus.upd_valid), 0);
        check("dbg_mispredict", 64'(bus.mispredict), 1);
        check("dbg_count", 64'(bus.count), 0);

        rec(64'h3100, 1'b1, 1'b0, 7'd3);
        tick();
        quiet();
        res(64'h3100, 1'b0);
        tick();
        quiet();
        check("pv0_upd_valid", 64'(bus.upd_valid), 1);
        check("pv0_no_mis", 64'(bus.mispredict), 0);

`ifdef LBP_UPD_PC_CHECK_EN
        rec(64'h2000, 1'b1, 1'b1, 7'd2);
        tick();
        quiet();
        res(64'h2004, 1'b0);
        tick();
        quiet();
        check("pcchk_mismatch", 64'(bus.pc_mismatch), 1);
        check("pcchk_no_upd", 64'(bus.upd_valid), 0);
        check("pcchk_no_mis", 64'(bus.mispredict), 0);
        check("pcchk_count", 64'(bus.count), 0);
        tick();
        check("pcchk_drop", 64'(bus.pc_mismatch), 0);
`endif

        rec(64'h7000, 1'b1, 1'b1, 7'd1);
        tick();
        rec(64'h7004, 1'b0, 1'b1, 7'd2);
        tick();
        quiet();
        res(64'h7000, 1'b0);
        tick();
        quiet();
        check("arst_pre_valid", 64'(bus.upd_valid), 1);
        check("arst_pre_count", 64'(bus.count), 1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_upd_valid", 64'(bus.upd_valid), 0);
        check("arst_mispredict", 64'(bus.mispredict), 0);
        check("arst_count", 64'(bus.count), 0);
        check("arst_ready", 64'(bus.rec_ready), 1);
        check("arst_upd_pc", bus.upd_pc, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
